pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised, elastic pipeline stage register: the general successor to the fixed per-stage register banks between the CPU pipeline stages. It moves a DATA_W-bit bundle (instruction, PC+8, memory read data, ALU result, …) from one stage to the next under a valid/ready handshake instead of a bare write-enable. It supports synchronous flush and a saturating back-pressure counter. Any stage boundary (F/D, D/E, E/M, M/W) instantiates it with the bundle width it needs.

## Interface
Parameters:
- DATA_W, 128, width of the payload bundle (e.g. 4×32 for the M/W bundle)
- STALL_CNT_W, 8, width of the saturating stall counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  upstream stage presents a bundle
- in_ready  output  1  this stage can accept a bundle this cycle
- in_data  input  DATA_W  upstream bundle
- flush  input  1  discard all held bundles (branch/exception kill)
- out_valid  output  1  bundle available to downstream
- out_ready  input  1  downstream accepts this cycle
- out_data  output  DATA_W  bundle to downstream
- stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Transfer in: in_valid && in_ready on a rising edge. Transfer out: out_valid && out_ready on a rising edge.
- Storage: a main register (main_v, main_d). With PIPE_STAGE_SKID_EN, a skid register (skid_v, skid_d) is added.
- out_valid = main_v; out_data = main_d.
- Main register update, per edge, skid disabled:
  - Load in_data into main when a transfer in occurs.
  - Else clear main_v when a transfer out occurs.
- Main register update, per edge, skid enabled:
  - If main is empty or a transfer out occurs, main loads from skid when skid_v=1, else from in_data on a transfer in.
  - A transfer in that cannot go to main goes to skid.
  - skid_v clears when skid drains into main.
- Ordering is strict FIFO. No bundle is duplicated or dropped except by flush or reset.
- Flush (priority over every transfer in the same cycle):
  - main_v, skid_v ← 0 and main_d, skid_d ← 0.
  - A bundle offered in the flush cycle is discarded, even though in_ready=1 that cycle.
  - stall_cnt is unaffected.
- Stall counter:
  - Increments on each edge where out_valid=1 and out_ready=0.
  - Holds at all-ones (2^STALL_CNT_W−1).
  - Cleared only by reset.
- When out_valid=0, out_data holds its last value, or 0 after reset/flush. Consumers must qualify it with out_valid.

## Timing
- Reset values: out_valid=0, out_data=0, stall_cnt=0, in_ready=1; skid_v=0, skid_d=0.
- Reset overrides flush and all transfers. Bundles held mid-operation are lost.
- Latency: in_data accepted at edge N appears on out_data after edge N (1 cycle).
- Throughput: 1 bundle/cycle when out_ready stays 1.
- in_ready, skid enabled: registered, in_ready = !skid_v, with no combinational path from out_ready. After out_ready falls with main full, exactly one more bundle is absorbed into skid, then in_ready=0 from the next cycle.
- in_ready, skid disabled: combinational, in_ready = !main_v || out_ready.
- Full (skid enabled): main_v=skid_v=1, in_ready=0. When out_ready returns, skid drains into main on that edge and in_ready=1 the following cycle.
- Empty: out_valid=0, and out_ready is ignored.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry elastic stage with registered in_ready. This breaks the ready timing path across stages.
- PIPE_STAGE_SKID_EN undefined: single entry with combinational in_ready. This gives the lowest area and is functionally equivalent to the classic enable-gated stage register when out_ready is tied to !stall.

## Test plan
- Reset mid-stream: load 0xA5A5_0000…, assert reset one cycle → out_valid=0, out_data=0, stall_cnt=0, in_ready=1 next cycle.
- Back-to-back streaming: out_ready=1, send 0x1,0x2,0x3 on consecutive cycles → out_data 0x1,0x2,0x3 on the following three cycles, no gaps.
- Back-pressure, skid enabled: drop out_ready while streaming 0x10,0x11,0x12 → 0x10 held, 0x11 in skid, in_ready=0, 0x12 held upstream. Release → 0x10,0x11,0x12 emerge in order.
- Flush with simultaneous transfer in: main and skid full, flush=1 with in_valid=1 and in_data=0x99 → out_valid=0 and in_ready=1 next cycle, and 0x99 never appears.
- Stall counter saturation, STALL_CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt reaches 15 and stays 15. Flush → stays 15. Reset → 0.
- Skid disabled: main full, out_ready=0 → in_ready=0 the same cycle. out_ready=1 with in_valid=1 → simultaneous dequeue and enqueue, out_valid stays 1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid version with registered in_ready.
module pipe_stage_reg #(
    parameter int DATA_W      = 128,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic              main_v;
    logic [DATA_W-1:0] main_d;
    logic              xfer_in;
    logic              xfer_out;

    assign out_valid = main_v;
    assign out_data  = main_d;
    assign xfer_out  = main_v && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_v;
    logic [DATA_W-1:0] skid_d;
    logic              main_free;

    assign in_ready  = !skid_v;
    assign xfer_in   = in_valid && in_ready;
    assign main_free = !main_v || xfer_out;

    // in_ready=0 whenever skid_v=1, so skid never refills while draining
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_v <= 1'b0;
            main_d <= '0;
            skid_v <= 1'b0;
            skid_d <= '0;
        end else if (main_free) begin
            if (skid_v) begin
                main_v <= 1'b1;
                main_d <= skid_d;
                skid_v <= 1'b0;
            end else if (xfer_in) begin
                main_v <= 1'b1;
                main_d <= in_data;
            end else begin
                main_v <= 1'b0;
            end
        end else if (xfer_in) begin
            skid_v <= 1'b1;
            skid_d <= in_data;
        end
    end
`else
    assign in_ready = !main_v || out_ready;
    assign xfer_in  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_v <= 1'b0;
            main_d <= '0;
        end else if (xfer_in) begin
            main_v <= 1'b1;
            main_d <= in_data;
        end else if (xfer_out) begin
            main_v <= 1'b0;
        end
    end
`endif

    logic [STALL_CNT_W-1:0] stall_q;

    // flush deliberately does not touch the counter
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (main_v && !out_ready && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;

endmodule
